inter_rr: RTL

// - N-master to M-slave request interconnect with per-master input FIFOs.
// - Each master word carries a slave select, an address and a value. Words queue per master.
// - A round-robin arbiter per slave forwards them over a valid/ready handshake.
// - Sits between the request generators and the slave units. It replaces the fixed 2x2 switch

---
 rtl/inter_rr.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/inter_rr.sv
// N-master to M-slave request fabric: per-master FIFOs feeding per-slave arbiters and output registers.
// Define INTER_RR_EN for round-robin arbitration; otherwise the lowest master index wins.
module inter_rr #(
  parameter int unsigned NUM_MASTER = 2,
  parameter int unsigned NUM_SLAVE  = 2,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned VAL_W      = 3,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned SEL_W     = $clog2(NUM_SLAVE),
  localparam int unsigned MW        = $clog2(NUM_MASTER),
  localparam int unsigned DW        = SEL_W + ADDR_W + VAL_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTER-1:0]       in_valid,
  input  logic [NUM_MASTER*DW-1:0]    data_in,
  output logic [NUM_MASTER-1:0]       in_ready,
  input  logic [NUM_SLAVE-1:0]        ready_slave,
  output logic [NUM_SLAVE-1:0]        valid_slave,
  output logic [NUM_SLAVE*ADDR_W-1:0] addr_out,
  output logic [NUM_SLAVE*VAL_W-1:0]  value_out,
  output logic [NUM_SLAVE*MW-1:0]     src_out,
  output logic [NUM_SLAVE-1:0]        handshake_slave
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DW-1:0]         r_mem  [NUM_MASTER][FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr [NUM_MASTER];
  logic [PTR_W-1:0]      r_rptr [NUM_MASTER];
  logic [CNT_W-1:0]      r_cnt  [NUM_MASTER];

  logic [NUM_MASTER-1:0] w_full;
  logic [NUM_MASTER-1:0] w_empty;
  logic [NUM_MASTER-1:0] w_push;
  logic [NUM_MASTER-1:0] w_pop;
  logic [DW-1:0]         w_head     [NUM_MASTER];
  logic [SEL_W-1:0]      w_head_sel [NUM_MASTER];

  logic [NUM_MASTER-1:0] w_cand    [NUM_SLAVE];
  logic [NUM_SLAVE-1:0]  w_free;
  logic [NUM_SLAVE-1:0]  w_gnt;
  logic [MW-1:0]         w_gnt_idx [NUM_SLAVE];

  logic [NUM_SLAVE-1:0]  r_valid;
  logic [NUM_SLAVE-1:0]  r_hs;
  logic [ADDR_W-1:0]     r_addr [NUM_SLAVE];
  logic [VAL_W-1:0]      r_val  [NUM_SLAVE];
  logic [MW-1:0]         r_src  [NUM_SLAVE];

`ifdef INTER_RR_EN
  logic [MW-1:0]         r_ptr  [NUM_SLAVE];
`endif

  // FIFO status and head decode
  always_comb begin
    for (int i = 0; i < NUM_MASTER; i++) begin
      w_full[i]     = (r_cnt[i] == CNT_W'(FIFO_DEPTH));
      w_empty[i]    = (r_cnt[i] == '0);
      w_push[i]     = in_valid[i] & ~w_full[i];
      w_head[i]     = r_mem[i][r_rptr[i]];
      w_head_sel[i] = w_head[i][DW-1 -: SEL_W];
    end
  end

  assign in_ready = ~w_full;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MASTER; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= data_in[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_MASTER; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTER; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
      end
    end
  end

  // Per-slave arbitration: search starts at the priority pointer (or master 0) and wraps
  always_comb begin
    int unsigned base;
    int unsigned k;
    base = 0;
    k    = 0;
    for (int j = 0; j < NUM_SLAVE; j++) begin
      w_free[j]    = ~r_valid[j] | ready_slave[j];
      w_gnt[j]     = 1'b0;
      w_gnt_idx[j] = '0;
      for (int i = 0; i < NUM_MASTER; i++) begin
        w_cand[j][i] = ~w_empty[i] & (w_head_sel[i] == SEL_W'(j));
      end
`ifdef INTER_RR_EN
      base = 32'(r_ptr[j]);
`else
      base = 0;
`endif
      for (int unsigned off = 0; off < NUM_MASTER; off++) begin
        k = (base + off) % NUM_MASTER;
        if (!w_gnt[j] && w_cand[j][MW'(k)]) begin
          w_gnt[j]     = 1'b1;
          w_gnt_idx[j] = MW'(k);
        end
      end
    end
  end

  // A head targets one slave only, so at most one slave pops any given master
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      for (int j = 0; j < NUM_SLAVE; j++) begin
        if (w_free[j] && w_gnt[j] && (w_gnt_idx[j] == MW'(i))) w_pop[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_hs    <= '0;
      for (int j = 0; j < NUM_SLAVE; j++) begin
        r_addr[j] <= '0;
        r_val[j]  <= '0;
        r_src[j]  <= '0;
      end
    end else begin
      r_hs <= r_valid & ready_slave;
      for (int j = 0; j < NUM_SLAVE; j++) begin
        if (w_free[j]) begin
          r_valid[j] <= w_gnt[j];
          if (w_gnt[j]) begin
            r_addr[j] <= w_head[w_gnt_idx[j]][VAL_W +: ADDR_W];
            r_val[j]  <= w_head[w_gnt_idx[j]][VAL_W-1:0];
            r_src[j]  <= w_gnt_idx[j];
          end
        end
      end
    end
  end

`ifdef INTER_RR_EN
  // Winner drops to lowest priority for the next round
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_SLAVE; j++) r_ptr[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_SLAVE; j++) begin
        if (w_free[j] && w_gnt[j]) begin
          r_ptr[j] <= (w_gnt_idx[j] == MW'(NUM_MASTER - 1)) ? '0 : w_gnt_idx[j] + MW'(1);
        end
      end
    end
  end
`endif

  assign valid_slave     = r_valid;
  assign handshake_slave = r_hs;

  for (genvar j = 0; j < NUM_SLAVE; j++) begin : g_out
    assign addr_out[j*ADDR_W +: ADDR_W] = r_addr[j];
    assign value_out[j*VAL_W +: VAL_W]  = r_val[j];
    assign src_out[j*MW +: MW]          = r_src[j];
  end

endmodule
